// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: clears the RAM after reset, then shares the single port between
// fixed-latency video scan-out reads (absolute priority) and an in-order host command FIFO.
module fb_arbiter #(
   parameter int unsigned   AW     = 17,
   parameter int unsigned   DW     = 32,
   parameter int unsigned   FDEPTH = 4,
   parameter logic [DW-1:0] FILL   = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_adr,
   output logic          vid_dvalid,
   output logic [DW-1:0] vid_dat,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic          host_we,
   input  logic [AW-1:0] host_adr,
   input  logic [DW-1:0] host_wdat,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdat,
   output logic          init_done,
   output logic [15:0]   conflicts,
   output logic          ram_we,
   output logic [AW-1:0] ram_adr,
   output logic [DW-1:0] ram_wdat,
   input  logic [DW-1:0] ram_rdat
);

   localparam int unsigned PW = $clog2(FDEPTH);
   localparam int unsigned EW = 1 + AW + DW;

   typedef enum logic {StClear, StRun} state_e;
   // TagVidZero: video request made during clear, answered with zero data
   typedef enum logic [1:0] {TagNone, TagVid, TagHost, TagVidZero} tag_e;

   state_e        state_q, state_d;
   logic [AW:0]   clr_cnt_q, clr_cnt_d;
   logic [PW:0]   wr_ptr_q, rd_ptr_q;
   logic [EW-1:0] fifo_q [FDEPTH];
   tag_e          tag_s1_q, tag_s2_q, tag_d;
   logic          we_d, init_d;
   logic [AW-1:0] adr_d;
   logic [DW-1:0] wdat_d;
   logic [15:0]   conflicts_d;

   logic          empty, full, push, pop;
   logic          head_we;
   logic [AW-1:0] head_adr;
   logic [DW-1:0] head_wdat;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign host_ready = (state_q == StRun) && !full;
   assign push = host_valid && host_ready;
   assign pop  = (state_q == StRun) && !vid_req && !empty;
   assign {head_we, head_adr, head_wdat} = fifo_q[rd_ptr_q[PW-1:0]];

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      we_d        = 1'b0;
      adr_d       = ram_adr;
      wdat_d      = ram_wdat;
      tag_d       = TagNone;
      init_d      = init_done;
      conflicts_d = conflicts;
      unique case (state_q)
         StClear: begin
            // The extra counter bit marks that the last address has already been written
            if (clr_cnt_q[AW]) begin
               state_d = StRun;
               init_d  = 1'b1;
            end else begin
               we_d      = 1'b1;
               adr_d     = clr_cnt_q[AW-1:0];
               wdat_d    = FILL;
               clr_cnt_d = clr_cnt_q + {{AW{1'b0}}, 1'b1};
            end
            if (vid_req) tag_d = TagVidZero;
         end
         StRun: begin
            if (vid_req) begin
               adr_d = vid_adr;
               tag_d = TagVid;
               if (!empty && conflicts != 16'hFFFF) conflicts_d = conflicts + 16'd1;
            end else if (!empty) begin
               we_d   = head_we;
               adr_d  = head_adr;
               wdat_d = head_wdat;
               tag_d  = head_we ? TagNone : TagHost;
            end
         end
         default: state_d = StClear;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StClear;
         clr_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         tag_s1_q    <= TagNone;
         tag_s2_q    <= TagNone;
         ram_we      <= 1'b0;
         ram_adr     <= '0;
         ram_wdat    <= FILL;
         vid_dvalid  <= 1'b0;
         vid_dat     <= '0;
         host_rvalid <= 1'b0;
         host_rdat   <= '0;
         init_done   <= 1'b0;
         conflicts   <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         if (push) wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, 1'b1};
         if (pop)  rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, 1'b1};
         tag_s1_q  <= tag_d;
         tag_s2_q  <= tag_s1_q;
         ram_we    <= we_d;
         ram_adr   <= adr_d;
         ram_wdat  <= wdat_d;
         init_done <= init_d;
         conflicts <= conflicts_d;
         vid_dvalid  <= (tag_s2_q == TagVid) || (tag_s2_q == TagVidZero);
         host_rvalid <= (tag_s2_q == TagHost);
         if (tag_s2_q == TagVid)          vid_dat <= ram_rdat;
         else if (tag_s2_q == TagVidZero) vid_dat <= '0;
         if (tag_s2_q == TagHost) host_rdat <= ram_rdat;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q[PW-1:0]] <= {host_we, host_adr, host_wdat};
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a 16-word synchronous RAM model (AW=4, FDEPTH=4).
module tb_fb_arbiter;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;
   localparam logic [31:0] FILL = 32'hA5A5A5A5;

   logic          clk, rst;
   logic          vid_req, vid_dvalid;
   logic [AW-1:0] vid_adr;
   logic [DW-1:0] vid_dat;
   logic          host_valid, host_ready, host_we, host_rvalid;
   logic [AW-1:0] host_adr;
   logic [DW-1:0] host_wdat, host_rdat;
   logic          init_done;
   logic [15:0]   conflicts;
   logic          ram_we;
   logic [AW-1:0] ram_adr;
   logic [DW-1:0] ram_wdat, ram_rdat;

   logic [31:0] mem [16] = '{default: 32'hDEADBEEF};
   int n_checks = 0;
   int n_pass   = 0;

   fb_arbiter #(.AW(AW), .DW(DW), .FDEPTH(4), .FILL(FILL)) dut (
      .clk(clk), .rst(rst),
      .vid_req(vid_req), .vid_adr(vid_adr), .vid_dvalid(vid_dvalid), .vid_dat(vid_dat),
      .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
      .host_adr(host_adr), .host_wdat(host_wdat), .host_rvalid(host_rvalid),
      .host_rdat(host_rdat), .init_done(init_done), .conflicts(conflicts),
      .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdat(ram_wdat), .ram_rdat(ram_rdat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_adr] <= ram_wdat;
      ram_rdat <= mem[ram_adr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; vid_req = 0; vid_adr = 0;
      host_valid = 0; host_we = 0; host_adr = 0; host_wdat = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ram", 32'({ram_we, ram_adr}), 32'h0);
      check("rst_wdat", ram_wdat, FILL);
      check("rst_flags", 32'({init_done, host_ready, vid_dvalid, host_rvalid}), 32'h0);
      check("rst_conf", 32'(conflicts), 32'h0);
      rst = 1'b0;

      // Clear pass, with one video request during the clear
      for (int i = 0; i < 16; i++) begin
         vid_req = (i == 5);
         tick();
         check("clr", 32'({ram_we, ram_adr, init_done, host_ready}), 32'({1'b1, 4'(i), 2'b00}));
         if (i >= 6 && i <= 8) check("clr_vid_v", 32'(vid_dvalid), 32'(i == 7));
         if (i == 7) check("clr_vid_d", vid_dat, 32'h0);
      end
      vid_req = 0;
      tick();
      check("clr_end", 32'({ram_we, init_done, host_ready}), 32'b011);

      // Back-to-back video reads of address 3
      vid_adr = 3;
      for (int k = 0; k < 6; k++) begin
         vid_req = (k < 3);
         tick();
         check("vlat_v", 32'(vid_dvalid), 32'(k >= 2 && k <= 4));
         if (k >= 2 && k <= 4) check("vlat_d", vid_dat, FILL);
      end

      // Preload addresses 5..7 through the host port
      for (int j = 0; j < 3; j++) begin
         host_valid = 1; host_we = 1; host_adr = 4'(5 + j); host_wdat = 32'(5 + j);
         tick();
         if (j > 0) check("pre_issue", 32'({ram_we, ram_adr}), 32'({1'b1, 4'(4 + j)}));
      end
      host_valid = 0;
      tick();
      tick();
      for (int k = 0; k < 6; k++) begin
         vid_req = (k < 3);
         vid_adr = 4'(5 + k);
         tick();
         check("vseq_v", 32'(vid_dvalid), 32'(k >= 2 && k <= 4));
         if (k >= 2 && k <= 4) check("vseq_d", vid_dat, 32'(k + 3));
      end
      vid_req = 0;

      // Host write then read of address 7
      host_valid = 1; host_we = 1; host_adr = 7; host_wdat = 32'h00010203;
      tick();
      host_we = 0; host_wdat = 0;
      tick();
      host_valid = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("hrd_v", 32'(host_rvalid), 32'(k == 3));
         if (k == 3) check("hrd_d", host_rdat, 32'h00010203);
      end

      // Priority and conflicts: one write queued, then 6 video cycles while 3 more are pushed
      check("conf_pre", 32'(conflicts), 32'd0);
      host_valid = 1; host_we = 1; host_adr = 8; host_wdat = 32'h100;
      tick();
      vid_req = 1;
      for (int k = 0; k < 6; k++) begin
         host_valid = (k < 3);
         host_adr = 4'(9 + k);
         host_wdat = 32'(32'h101 + k);
         tick();
         check("pri_nowe", 32'(ram_we), 32'd0);
         check("pri_ready", 32'(host_ready), 32'(k < 2));
      end
      check("pri_conf", 32'(conflicts), 32'd6);
      vid_req = 0; host_valid = 0;
      for (int j = 0; j < 5; j++) begin
         tick();
         if (j < 4) begin
            check("pri_issue", 32'({ram_we, ram_adr}), 32'({1'b1, 4'(8 + j)}));
            check("pri_wdat", ram_wdat, 32'(32'h100 + j));
         end else check("pri_idle", 32'(ram_we), 32'd0);
      end

      // Simultaneous push/pop with two entries queued
      vid_req = 1;
      for (int k = 0; k < 2; k++) begin
         host_valid = 1; host_we = 1; host_adr = 4'(k); host_wdat = 32'(32'h200 + k);
         tick();
      end
      vid_req = 0;
      for (int k = 2; k <= 8; k++) begin
         host_valid = (k <= 6);
         host_adr = 4'(k);
         host_wdat = 32'(32'h200 + k);
         if (k <= 6) check("pp_ready", 32'(host_ready), 32'd1);
         tick();
         check("pp_issue", 32'({ram_we, ram_adr}), 32'({1'b1, 4'(k - 2)}));
         check("pp_wdat", ram_wdat, 32'(32'h200 + k - 2));
      end
      host_valid = 0;
      tick();
      check("pp_idle", 32'(ram_we), 32'd0);
      check("pp_conf", 32'(conflicts), 32'd7);

      // Reset with host reads queued and video reads in flight
      vid_req = 1; vid_adr = 2;
      for (int k = 0; k < 4; k++) begin
         host_valid = (k < 3); host_we = 0; host_adr = 4'(1 + k);
         tick();
      end
      host_valid = 0; vid_req = 0;
      rst = 1'b1;
      #1;
      check("mrst_ram", 32'({ram_we, ram_adr}), 32'h0);
      check("mrst_wdat", ram_wdat, FILL);
      check("mrst_flags", 32'({init_done, host_ready, vid_dvalid, host_rvalid}), 32'h0);
      check("mrst_rdat", host_rdat, 32'h0);
      check("mrst_vdat", vid_dat, 32'h0);
      check("mrst_conf", 32'(conflicts), 32'h0);
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 1) rst = 1'b0;
         check("mrst_nopulse", 32'({vid_dvalid, host_rvalid}), 32'h0);
         if (k >= 2) check("mrst_clr", 32'({ram_we, ram_adr}), 32'({1'b1, 4'(k - 2)}));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Owns the single-port 32-bit framebuffer RAM and shares it between the video scan-out fetch and a host port that draws into the framebuffer.
- After reset it clears the whole RAM to a fill word, then arbitrates every cycle.
- Video has absolute priority and a fixed return latency, so the 3-clock/pixel, 4-pixel/word scan-out never underruns.
- Host accesses are buffered in a small command FIFO and complete in order.

Parameters:
AW, 17, RAM word-address width (depth 2^AW words)
DW, 32, RAM/data word width (4 packed 8-bit pixels)
FDEPTH, 4, host command FIFO depth, power of two, >=2
FILL, 32'h00000000, word written to every address during clear

Ports:
clk  in  1  single clock (video pixel-domain clock)
rst  in  1  asynchronous active-high reset
vid_req  in  1  video read request, one-cycle strobe
vid_adr  in  AW  video word address
vid_dvalid  out  1  video read data valid
vid_dat  out  DW  video read data
host_valid  in  1  host command valid
host_ready  out  1  host command accepted when valid&&ready
host_we  in  1  1=write, 0=read
host_adr  in  AW  host word address
host_wdat  in  DW  host write data
host_rvalid  out  1  host read data valid, one cycle
host_rdat  out  DW  host read data
init_done  out  1  clear pass complete
conflicts  out  16  saturating count of cycles a pending host command was held off by vid_req
ram_we  out  1  RAM write enable (registered)
ram_adr  out  AW  RAM address (registered)
ram_wdat  out  DW  RAM write data (registered)
ram_rdat  in  DW  RAM read data; synchronous, valid the cycle after ram_adr is captured

Behaviour:
- Reset (async assert, applied at once): state=CLEAR, clear address=0, FIFO empty, in-flight tags cleared.
- Output values in reset: ram_we=0, ram_adr=0, ram_wdat=FILL, vid_dvalid=0, vid_dat=0, host_ready=0, host_rvalid=0, host_rdat=0, init_done=0, conflicts=0.
- Reset mid-operation: in-flight reads are dropped with no valid pulse, FIFO contents are lost, and the clear pass restarts from address 0.
- CLEAR state:
  - Each cycle: ram_we=1, ram_wdat=FILL, ram_adr=clear address, then the clear address increments.
  - After address 2^AW-1 is issued, go to RUN and set init_done=1 on the same edge. init_done stays 1 until reset.
  - host_ready=0 throughout.
  - A vid_req in CLEAR does not access RAM. It still gets vid_dvalid=1 with vid_dat=0 at the normal latency.
- RUN state, slot selection each edge, in priority order:
  1. vid_req=1: issue a video read (ram_we=0, ram_adr=vid_adr).
  2. Else FIFO non-empty: pop the head and issue it (ram_we=host_we, ram_adr, ram_wdat).
  3. Else ram_we=0; ram_adr holds its value.
- Video latency: vid_req sampled at edge E0 -> ram_adr registered at E0 -> RAM captures at E1 -> vid_dvalid=1 and vid_dat=ram_rdat registered at E2. Exactly 2 edges, for back-to-back requests too.
- A two-stage tag pipeline (none/video/host-read) routes ram_rdat to the correct return port. A host write carries tag none.
- Host handshake:
  - host_ready = (state==RUN) && FIFO not full. Full means FDEPTH entries.
  - Push on valid&&ready. Push and pop in the same cycle are both honoured; count is unchanged.
  - A command pushed at E0 is eligible for issue at E1 at the earliest. Minimum host read latency is push edge + 3 edges to host_rvalid.
  - Reads return in issue order. A write is visible to any access issued on a later cycle.
  - A host write followed by a video read of the same address sees the new data if the write issued first.
- conflicts: +1 on every RUN cycle with vid_req=1 and FIFO non-empty. Saturates at 16'hFFFF with no wrap.
- Starvation: a continuous vid_req may starve the host indefinitely. The scan-out duty is 1 request in 12 cycles, so this does not happen in use.
- Widths: FIFO pointers are log2(FDEPTH)+1 bits so full and empty can be told apart. The clear counter is AW+1 bits to detect wrap.

Test Plan:
- Clear pass (AW=4, FILL=32'hA5A5A5A5): release rst -> 16 consecutive writes to addresses 0..15. init_done rises on the edge after address 15 is issued. host_ready stays 0 until then. A read of any address returns A5A5A5A5.
- Video latency: vid_req with vid_adr=3 pulsed at edges 100, 101, 102 -> vid_dvalid=1 at edges 102, 103, 104 with the data from addresses 3, 3, 3. Repeat with addresses 5, 6, 7 preloaded to 0x05, 0x06, 0x07 -> those values are returned in order.
- Host write/read: write addr 7 = 32'h00010203, then read addr 7, no video traffic -> host_rvalid one cycle with host_rdat=32'h00010203, 3 edges after the read is pushed.
- Priority and conflicts: push 4 writes (FDEPTH=4) while vid_req is held high for 6 cycles:
  - host_ready=0 once the FIFO holds 4 entries;
  - no ram_we during the video cycles;
  - conflicts=6;
  - the 4 writes then issue on 4 consecutive cycles.
- Simultaneous push/pop: with 2 entries queued and vid_req low, hold host_valid for 5 cycles -> host_ready never drops, and all 7 commands issue in order.
- Reset mid-operation: assert rst with 3 host reads queued and 1 video read in flight -> no host_rvalid or vid_dvalid pulses after the edge, all outputs take reset values, and the clear restarts at address 0.
